// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and the slave responder state type.
// Also holds the transfer-legality and byte-lane helpers used at address accept.
package ahb2_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HSIZE_8BITS    = 3'b000;
   localparam logic [2:0] HSIZE_16BITS   = 3'b001;
   localparam logic [2:0] HSIZE_32BITS   = 3'b010;
   localparam logic [2:0] HSIZE_64BITS   = 3'b011;
   localparam logic [2:0] HSIZE_128BITS  = 3'b100;
   localparam logic [2:0] HSIZE_256BITS  = 3'b101;
   localparam logic [2:0] HSIZE_512BITS  = 3'b110;
   localparam logic [2:0] HSIZE_1024BITS = 3'b111;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } ahb2_slv_state_e;

   function automatic logic size_legal(input logic [2:0] size, input logic [1:0] a);
      logic ok;
      ok = 1'b1;
      if (size > HSIZE_32BITS)                       ok = 1'b0;
      else if (size == HSIZE_16BITS && a[0])         ok = 1'b0;
      else if (size == HSIZE_32BITS && a != 2'b00)   ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         HSIZE_8BITS:  be = 4'b0001 << a;
         HSIZE_16BITS: be = 4'b0011 << {a[1], 1'b0};
         default:      be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb2_sram_slv_mem.sv
// Word-wide SRAM array with per-byte write enables and an asynchronous read port.
module ahb2_sram_slv_mem #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb2_sram_slv.sv
// AHB2 slave responder in front of an on-chip SRAM: programmable wait states,
// byte/halfword/word writes and a two-cycle ERROR response for illegal transfers.
//
// state | meaning
// IDLE  | no data phase pending, ready/OKAY
// WAIT  | data phase stalled, counter running down
// LAST  | final data-phase cycle, read data driven, write commits at its end
// ERR1  | first ERROR cycle, not ready
// ERR2  | second ERROR cycle, ready; a new address may be accepted here
module ahb2_sram_slv
   import ahb2_pkg::*;
#(
   parameter int MEM_AW      = 12,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        hclk,
   input  logic        hreset_n,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic [31:0] hwdata,
   input  logic        hreadyi,
   output logic [31:0] hrdata,
   output logic        hreadyo,
   output logic [1:0]  hresp
);

   localparam int         WORD_AW   = MEM_AW - 2;
   localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

   ahb2_slv_state_e      state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [WORD_AW-1:0]   addr_q;
   logic                 write_q;
   logic [3:0]           be_q;
   logic                 accept;
   logic                 mem_we;
   logic [31:0]          mem_rdata;
   logic                 unused_ok;

   // Only states that present hreadyo=1 can end an address phase.
   assign accept = hsel & hreadyi & htrans[1] &
                   (state_q inside {ST_IDLE, ST_LAST, ST_ERR2});

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 3'd0) state_d = ST_LAST;
            else               cnt_d   = cnt_q - 3'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            if (accept) begin
               if (!size_legal(hsize, haddr[1:0])) begin
                  state_d = ST_ERR1;
               end else if (WAIT_CYCLES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = ST_LAST;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         be_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= haddr[MEM_AW-1:2];
            write_q <= hwrite;
            be_q    <= byte_en(hsize, haddr[1:0]);
         end
      end
   end

   assign mem_we  = (state_q == ST_LAST) && write_q;
   assign hrdata  = ((state_q == ST_LAST) && !write_q) ? mem_rdata : 32'h0;
   assign hreadyo = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
   assign hresp   = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

   ahb2_sram_slv_mem #(.AW(WORD_AW)) u_mem (
      .clk   (hclk),
      .we    (mem_we),
      .be    (be_q),
      .addr  (addr_q),
      .wdata (hwdata),
      .rdata (mem_rdata)
   );

   // Burst type, protection and decoder-owned address bits have no effect here.
   assign unused_ok = ^{hburst, hprot, haddr[31:MEM_AW]};

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Directed bench for ahb2_sram_slv: a zero-wait instance driven from a vector table
// and a three-wait instance exercised with hand-written burst and reset sequences.
module tb_ahb2_sram_slv;
   import ahb2_pkg::*;

   logic        hclk = 1'b0;
   logic        hreset_n;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        blk;
   logic        use_w3;
   logic        hreadyi;

   logic [31:0] rd0, rd3, hrdata_c;
   logic        rdy0, rdy3, hreadyo_c;
   logic [1:0]  rs0, rs3, hresp_c;

   int tests = 0;
   int fails = 0;

   always #5 hclk = ~hclk;

   assign hrdata_c  = use_w3 ? rd3  : rd0;
   assign hreadyo_c = use_w3 ? rdy3 : rdy0;
   assign hresp_c   = use_w3 ? rs3  : rs0;
   assign hreadyi   = hreadyo_c & ~blk;

   ahb2_sram_slv #(.MEM_AW(12), .WAIT_CYCLES(0)) dut_w0 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
      .hreadyi(hreadyi), .hrdata(rd0), .hreadyo(rdy0), .hresp(rs0)
   );

   ahb2_sram_slv #(.MEM_AW(12), .WAIT_CYCLES(3)) dut_w3 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
      .hreadyi(hreadyi), .hrdata(rd3), .hreadyo(rdy3), .hresp(rs3)
   );

   typedef struct {
      logic        sel;
      logic        blk;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   localparam int NV = 27;
   vec_t vt [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      return 32'h5A00_0000 ^ (a * 32'h0001_0001);
   endfunction

   task automatic do_reset();
      @(posedge hclk); #1;
      hreset_n = 1'b0;
      hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_32BITS;
      haddr = 32'h0; hwdata = 32'h0; blk = 1'b0;
      repeat (2) @(posedge hclk);
      #1 hreset_n = 1'b1;
   endtask

   // Word burst master: holds each address until hreadyo, drives hwdata in the data phase.
   task automatic run_burst(input logic wr, input logic [31:0] base, input int n,
                            input logic [31:0] xorv, input int exp_stall,
                            input int exp_cycles, input string name);
      int     issued, done, t, stall;
      logic   r;
      issued = 1; done = 0; t = 0; stall = 0;
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = HSIZE_32BITS;
      haddr = base; hwdata = 32'h0;
      @(negedge hclk);
      check({name, "_addr_rdy"}, 64'(hreadyo_c), 64'd1);
      @(posedge hclk); #1;
      if (issued < n) begin
         haddr = base + 32'(4 * issued); htrans = HTRANS_SEQ; issued++;
      end else begin
         hsel = 1'b0; htrans = HTRANS_IDLE;
      end
      hwdata = pat(base) ^ xorv;
      while (done < n && t < 40) begin
         @(negedge hclk);
         t++;
         r = hreadyo_c;
         if (r) begin
            check({name, "_resp"}, 64'(hresp_c), 64'(HRESP_OKAY));
            check({name, "_rdata"}, 64'(hrdata_c),
                  wr ? 64'd0 : 64'(pat(base + 32'(4 * done)) ^ xorv));
            check({name, "_stall"}, 64'(stall), 64'(exp_stall));
            stall = 0;
            done++;
         end else begin
            stall++;
         end
         @(posedge hclk); #1;
         if (r) begin
            if (issued < n) begin
               haddr = base + 32'(4 * issued); htrans = HTRANS_SEQ; issued++;
            end else begin
               hsel = 1'b0; htrans = HTRANS_IDLE;
            end
         end
         hwdata = (done < n) ? (pat(base + 32'(4 * done)) ^ xorv) : 32'h0;
      end
      check({name, "_cycles"}, 64'(t), 64'(exp_cycles));
      check({name, "_done"}, 64'(done), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      hburst = HBURST_INCR4;
      hprot  = 4'b0011;
      use_w3 = 1'b0;
      hreset_n = 1'b0;
      hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_32BITS;
      haddr = 32'h0; hwdata = 32'h0; blk = 1'b0;

      //        sel  blk trans          wr    size           addr          wdata          rdy  resp         rdata
      vt[0]  = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[1]  = '{1'b1,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_32BITS,32'h10,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[2]  = '{1'b1,1'b0,HTRANS_NONSEQ,1'b0,HSIZE_32BITS,32'h10,       32'hDEADBEEF,  1'b1,HRESP_OKAY, 32'h0};
      vt[3]  = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h0,         1'b1,HRESP_OKAY, 32'hDEADBEEF};
      vt[4]  = '{1'b1,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_32BITS,32'h20,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[5]  = '{1'b1,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_8BITS, 32'h21,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[6]  = '{1'b1,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_16BITS,32'h22,       32'h0000_1100, 1'b1,HRESP_OKAY, 32'h0};
      vt[7]  = '{1'b1,1'b0,HTRANS_NONSEQ,1'b0,HSIZE_32BITS,32'h20,       32'hAABB_0000, 1'b1,HRESP_OKAY, 32'h0};
      vt[8]  = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h0,         1'b1,HRESP_OKAY, 32'hAABB_1100};
      vt[9]  = '{1'b1,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_32BITS,32'h12,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[10] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h12345678,  1'b0,HRESP_ERROR,32'h0};
      vt[11] = '{1'b1,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_64BITS,32'h10,       32'h12345678,  1'b1,HRESP_ERROR,32'h0};
      vt[12] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h87654321,  1'b0,HRESP_ERROR,32'h0};
      vt[13] = '{1'b1,1'b0,HTRANS_NONSEQ,1'b0,HSIZE_32BITS,32'h10,       32'h87654321,  1'b1,HRESP_ERROR,32'h0};
      vt[14] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h0,         1'b1,HRESP_OKAY, 32'hDEADBEEF};
      vt[15] = '{1'b1,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_16BITS,32'h11,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[16] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'hFFFFFFFF,  1'b0,HRESP_ERROR,32'h0};
      vt[17] = '{1'b1,1'b0,HTRANS_BUSY,  1'b1,HSIZE_32BITS,32'h10,       32'hFFFFFFFF,  1'b1,HRESP_ERROR,32'h0};
      vt[18] = '{1'b1,1'b0,HTRANS_IDLE,  1'b1,HSIZE_32BITS,32'h10,       32'hFFFFFFFF,  1'b1,HRESP_OKAY, 32'h0};
      vt[19] = '{1'b1,1'b1,HTRANS_NONSEQ,1'b1,HSIZE_32BITS,32'h10,       32'hFFFFFFFF,  1'b1,HRESP_OKAY, 32'h0};
      vt[20] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'hFFFFFFFF,  1'b1,HRESP_OKAY, 32'h0};
      vt[21] = '{1'b1,1'b0,HTRANS_NONSEQ,1'b0,HSIZE_32BITS,32'h10,       32'hFFFFFFFF,  1'b1,HRESP_OKAY, 32'h0};
      vt[22] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h0,         1'b1,HRESP_OKAY, 32'hDEADBEEF};
      vt[23] = '{1'b0,1'b0,HTRANS_NONSEQ,1'b1,HSIZE_32BITS,32'h10,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[24] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h0BAD0BAD,  1'b1,HRESP_OKAY, 32'h0};
      vt[25] = '{1'b1,1'b0,HTRANS_NONSEQ,1'b0,HSIZE_32BITS,32'h10,       32'h0,         1'b1,HRESP_OKAY, 32'h0};
      vt[26] = '{1'b0,1'b0,HTRANS_IDLE,  1'b0,HSIZE_32BITS,32'h00,       32'h0,         1'b1,HRESP_OKAY, 32'hDEADBEEF};

      do_reset();

      for (int i = 0; i < NV; i++) begin
         @(posedge hclk); #1;
         hsel = vt[i].sel; blk = vt[i].blk; htrans = vt[i].trans; hwrite = vt[i].wr;
         hsize = vt[i].size; haddr = vt[i].addr; hwdata = vt[i].wdata;
         @(negedge hclk);
         check($sformatf("vec%0d", i), {29'd0, hreadyo_c, hresp_c, hrdata_c},
               {29'd0, vt[i].rdy, vt[i].resp, vt[i].rdata});
      end

      @(posedge hclk); #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; blk = 1'b0;
      run_burst(1'b1, 32'h80, 4, 32'h0, 0, 4, "w0_wburst");
      run_burst(1'b0, 32'h80, 4, 32'h0, 0, 4, "w0_rburst");

      use_w3 = 1'b1;
      do_reset();
      @(negedge hclk);
      check("w3_reset_rdy", 64'(hreadyo_c), 64'd1);
      check("w3_reset_resp", 64'(hresp_c), 64'(HRESP_OKAY));

      run_burst(1'b1, 32'h40, 4, 32'h0, 3, 16, "w3_wburst");
      run_burst(1'b0, 32'h40, 4, 32'h0, 3, 16, "w3_rburst");
      run_burst(1'b0, 32'h44, 1, 32'h0, 3, 4, "w3_single");

      // Reset while a write sits in WAIT: outputs return at once and memory keeps old data.
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_32BITS; haddr = 32'h40;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF_FFFF;
      @(negedge hclk);
      check("rst_pre_rdy", 64'(hreadyo_c), 64'd0);
      #2 hreset_n = 1'b0;
      #1;
      check("rst_now", {29'd0, hreadyo_c, hresp_c, hrdata_c}, {29'd0, 1'b1, HRESP_OKAY, 32'h0});
      @(posedge hclk); #1;
      @(posedge hclk); #1;
      hreset_n = 1'b1;
      run_burst(1'b0, 32'h40, 1, 32'h0, 3, 4, "rst_after");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
